if_prefetch_buffer: RTL and testbench

Instruction prefetch queue between the instruction memory port and the IF stage of the 5-stage pipeline. It issues sequential word fetches over a request/response handshake to a memory of variable latency, and buffers returned instructions in order. It presents one instruction with its PC per cycle to the IF/ID register. On a redirect (taken branch or jump resolved in EX) it restarts fetch at the new PC and drops every stale instruction, both buffered and still in flight.

---
 rtl/if_prefetch_buffer.sv | 109 ++++++++++
 tb/tb_if_prefetch_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch queue: credit-limited sequential fetch, in-order buffering
// of returned words, and redirect flush of both buffered and in-flight fetches.
module if_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus_4,
    input  logic        out_ready
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_r;
    logic [31:0]   rsp_pc_r;
    logic [31:0]   instr_mem_r [DEPTH];
    logic [31:0]   pc_mem_r    [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] discard_r;

    logic          credit_s;
    logic          req_fire_s;
    logic          rsp_fire_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   redirect_aligned_s;

    // Request credit, handshake qualifiers and head-of-queue presentation
    always_comb begin
        redirect_aligned_s = redirect_pc & 32'hFFFF_FFFC;
        // buffered plus in-flight fetches may never exceed the queue size
        credit_s       = ({1'b0, count_r} + {1'b0, outstanding_r}) < DEPTH_W;
        imem_req_valid = rst_n & ~redirect_valid & credit_s;
        imem_req_addr  = fetch_pc_r;
        req_fire_s     = imem_req_valid & imem_req_ready;
        rsp_fire_s     = imem_rsp_valid & (outstanding_r != CW'(0));
        push_s         = rsp_fire_s & ~redirect_valid & (discard_r == CW'(0));
        out_valid      = (count_r != CW'(0));
        pop_s          = out_valid & out_ready & ~redirect_valid;
        if (out_valid) begin
            out_instruction = instr_mem_r[rd_ptr_r];
            out_pc          = pc_mem_r[rd_ptr_r];
            out_pc_plus_4   = pc_mem_r[rd_ptr_r] + 32'd4;
        end else begin
            out_instruction = 32'd0;
            out_pc          = 32'd0;
            out_pc_plus_4   = 32'd0;
        end
    end

    // Fetch/response PCs, queue contents, pointers and credit counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            rd_ptr_r      <= PW'(0);
            wr_ptr_r      <= PW'(0);
            count_r       <= CW'(0);
            outstanding_r <= CW'(0);
            discard_r     <= CW'(0);
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem_r[i] <= 32'd0;
                pc_mem_r[i]    <= 32'd0;
            end
        end else if (redirect_valid) begin
            fetch_pc_r    <= redirect_aligned_s;
            rsp_pc_r      <= redirect_aligned_s;
            rd_ptr_r      <= PW'(0);
            wr_ptr_r      <= PW'(0);
            count_r       <= CW'(0);
            // every fetch still in flight after this cycle belongs to the old stream
            outstanding_r <= outstanding_r - CW'(rsp_fire_s);
            discard_r     <= outstanding_r - CW'(rsp_fire_s);
        end else begin
            if (req_fire_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if (push_s) begin
                instr_mem_r[wr_ptr_r] <= imem_rsp_data;
                pc_mem_r[wr_ptr_r]    <= rsp_pc_r;
                wr_ptr_r              <= wr_ptr_r + PW'(1);
                rsp_pc_r              <= rsp_pc_r + 32'd4;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r       <= count_r + CW'(push_s) - CW'(pop_s);
            outstanding_r <= outstanding_r + CW'(req_fire_s) - CW'(rsp_fire_s);
            if (rsp_fire_s && (discard_r != CW'(0))) begin
                discard_r <= discard_r - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Directed and randomised bench for if_prefetch_buffer: an in-order variable-latency
// memory model plus a PC/instruction scoreboard on every consumed head entry.
module tb_if_prefetch_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus_4;
    logic        out_ready = 1'b0;

    if_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_instruction(out_instruction),
        .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t    mem_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_due = -1;
    int          lat = 1;
    int          max_inflight = 0;
    int          n_pop = 0;
    int          n_fire = 0;
    logic        ready_fixed = 1'b1;
    logic        ready_rand = 1'b0;
    logic        ordy_fixed = 1'b1;
    logic        ordy_rand = 1'b0;
    logic        fired = 1'b0;
    logic        popped = 1'b0;
    logic        rspv = 1'b0;
    logic [31:0] fire_addr = 32'd0;
    logic [31:0] pop_pc = 32'd0;
    logic [31:0] exp_pc = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs mid-cycle, then sample handshakes and score pops.
    task automatic step(input logic rdv, input logic [31:0] rdpc);
        int due;
        @(negedge clk);
        redirect_valid = rdv;
        redirect_pc    = rdpc;
        imem_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fixed;
        out_ready      = ordy_rand ? 1'($urandom_range(0, 1)) : ordy_fixed;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'd0;
        end
        rspv = imem_rsp_valid;
        #1;
        fired     = imem_req_valid && imem_req_ready;
        fire_addr = imem_req_addr;
        if (fired) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: imem_req_addr, due: due});
            if (mem_q.size() > max_inflight) max_inflight = mem_q.size();
            n_fire++;
        end
        popped = out_valid && out_ready && !rdv;
        pop_pc = out_pc;
        if (!out_valid) begin
            check_eq("idle_outputs_zero", out_pc | out_instruction | out_pc_plus_4, 32'd0);
        end
        if (popped) begin
            check_eq("pop_pc", out_pc, exp_pc);
            check_eq("pop_instruction", out_instruction, mem_word(exp_pc));
            check_eq("pop_pc_plus_4", out_pc_plus_4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            n_pop++;
        end
        if (rdv) exp_pc = rdpc & 32'hFFFF_FFFC;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        out_ready      = 1'b0;
        mem_q.delete();
        last_due = -1;
        exp_pc   = 32'h0000_0000;
        #1;
        check_eq("rst_req_valid", imem_req_valid, 32'd0);
        check_eq("rst_req_addr", imem_req_addr, 32'h0000_0000);
        check_eq("rst_out_valid", out_valid, 32'd0);
        check_eq("rst_out_instruction", out_instruction, 32'd0);
        check_eq("rst_out_pc", out_pc, 32'd0);
        check_eq("rst_out_pc_plus_4", out_pc_plus_4, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_pop(input string tag, input logic [31:0] exp);
        int k = 0;
        do begin
            step(1'b0, 32'd0);
            k++;
        end while (!popped && k < 40);
        check_eq({tag, "_seen"}, popped, 32'd1);
        check_eq(tag, pop_pc, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset release, L=1: back-to-back fetches and one instruction per cycle
        lat = 1; ready_fixed = 1'b1; ordy_fixed = 1'b1;
        do_reset();
        step(1'b0, 32'd0);
        check_eq("t1_fire0", fired, 32'd1);
        check_eq("t1_addr0", fire_addr, 32'h0);
        check_eq("t1_no_valid_c0", out_valid, 32'd0);
        step(1'b0, 32'd0);
        check_eq("t1_addr1", fire_addr, 32'h4);
        check_eq("t1_no_valid_c1", out_valid, 32'd0);
        step(1'b0, 32'd0);
        check_eq("t1_addr2", fire_addr, 32'h8);
        check_eq("t1_pop0", pop_pc, 32'h0);
        step(1'b0, 32'd0);
        check_eq("t1_pop1", pop_pc, 32'h4);
        step(1'b0, 32'd0);
        check_eq("t1_pop2", pop_pc, 32'h8);
        check_eq("t1_pop2_pc4", out_pc_plus_4, 32'hC);

        // Consumer stalled: only DEPTH fetches issue, then in-order drain
        do_reset();
        ordy_fixed = 1'b0; n_fire = 0;
        repeat (10) step(1'b0, 32'd0);
        check_eq("t2_fire_count", 32'(n_fire), 32'd4);
        check_eq("t2_req_blocked", imem_req_valid, 32'd0);
        check_eq("t2_head_valid", out_valid, 32'd1);
        check_eq("t2_head_pc", out_pc, 32'h0);
        ordy_fixed = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'd0);
            check_eq("t2_drain_pop", popped, 32'd1);
            check_eq("t2_drain_pc", pop_pc, 32'(4 * i));
        end

        // Redirect with three stale fetches, L=3
        lat = 3;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0);
            check_eq("t3_stale_addr", fire_addr, 32'(4 * i));
        end
        step(1'b1, 32'h100);
        check_eq("t3_redir_no_req", fired, 32'd0);
        check_eq("t3_redir_rsp_present", rspv, 32'd1);
        step(1'b0, 32'd0);
        check_eq("t3_new_fire", fired, 32'd1);
        check_eq("t3_new_addr", fire_addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0);
            check_eq("t3_gap_invalid", out_valid, 32'd0);
        end
        step(1'b0, 32'd0);
        check_eq("t3_first_valid", out_valid, 32'd1);
        check_eq("t3_first_pc", out_pc, 32'h100);
        check_eq("t3_first_instr", out_instruction, mem_word(32'h100));

        // Redirect coinciding with a response and a would-be pop, L=2
        lat = 2;
        do_reset();
        repeat (6) step(1'b0, 32'd0);
        step(1'b1, 32'h300);
        check_eq("t4_head_valid", out_valid, 32'd1);
        check_eq("t4_rsp_same_cycle", rspv, 32'd1);
        check_eq("t4_no_pop", popped, 32'd0);
        wait_pop("t4_first_pc", 32'h300);

        // Misaligned redirect target and 32-bit PC wraparound
        step(1'b1, 32'h203);
        step(1'b0, 32'd0);
        check_eq("t5_fire", fired, 32'd1);
        check_eq("t5_aligned_addr", fire_addr, 32'h200);
        wait_pop("t5_aligned_pc", 32'h200);
        step(1'b1, 32'hFFFF_FFF8);
        wait_pop("t5_wrap_pc0", 32'hFFFF_FFF8);
        wait_pop("t5_wrap_pc1", 32'hFFFF_FFFC);
        wait_pop("t5_wrap_pc2", 32'h0000_0000);

        // Random ready/out_ready, latency 1..5, occasional random redirects
        do_reset();
        ready_rand = 1'b1; ordy_rand = 1'b1; max_inflight = 0; n_pop = 0;
        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) lat = $urandom_range(1, 5);
            if ($urandom_range(0, 39) == 0) step(1'b1, $urandom());
            else step(1'b0, 32'd0);
        end
        check_eq("rand_inflight_le_depth", 32'(max_inflight <= DEPTH), 32'd1);
        check_eq("rand_progress", 32'(n_pop >= 100), 32'd1);
        ready_rand = 1'b0; ordy_rand = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
